ddr_burst_sequencer: RTL and testbench

Request-level front end for one MCB user port (p0) of the DDR2 memory interface. Accepts single write or read burst requests (address, length) over a valid/ready handshake. For writes, streams data into the MCB write FIFO and then issues the command. For reads, issues the command, drains the MCB read FIFO and returns data as a registered stream. Sits between the board test/host-bridge FSMs and `ddr_interface`, in the `c3_clk0` domain.

---
 rtl/ddr_seq_pkg.sv | 12 +
 rtl/ddr_seq_timeout.sv | 19 +
 rtl/ddr_burst_sequencer.sv | 166 ++++++++++++++++
 tb/tb_ddr_burst_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_seq_pkg.sv
// ddr_seq_pkg: state encoding, MCB command opcodes and burst limit shared by the burst sequencer.
package ddr_seq_pkg;
    localparam logic [2:0] CAL    = 3'd0;
    localparam logic [2:0] IDLE   = 3'd1;
    localparam logic [2:0] WFILL  = 3'd2;
    localparam logic [2:0] WCMD   = 3'd3;
    localparam logic [2:0] RCMD   = 3'd4;
    localparam logic [2:0] RDRAIN = 3'd5;
    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;
    localparam int MAX_BL = 64;
endpackage

// File: rtl/ddr_seq_timeout.sv
// ddr_seq_timeout: read-drain watchdog, counts idle cycles and flags expiry at all-ones.
// Instantiated by ddr_burst_sequencer only when DDR_SEQ_TIMEOUT_EN is defined.
module ddr_seq_timeout #(
    parameter int TMO_W = 12
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_run,
    input  logic i_clr,
    output logic o_expired
);
    logic [TMO_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) r_cnt <= '0;
        else          r_cnt <= (!i_run || i_clr) ? '0 : r_cnt + 1'b1;

    assign o_expired = &r_cnt;
endmodule

// File: rtl/ddr_burst_sequencer.sv
// ddr_burst_sequencer: single-burst request front end for MCB port p0 (write fill + cmd, read cmd + drain).
// Optional read-drain timeout enabled by defining DDR_SEQ_TIMEOUT_EN.
module ddr_burst_sequencer #(
    parameter int DATA_W = 64,
    parameter int MAX_BL = ddr_seq_pkg::MAX_BL,
    parameter int TMO_W  = 12
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  calib_done,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [29:0]           req_addr,
    input  logic [6:0]            req_len,
    input  logic                  wdat_valid,
    output logic                  wdat_ready,
    input  logic [DATA_W-1:0]     wdat_data,
    output logic                  rdat_valid,
    output logic [DATA_W-1:0]     rdat_data,
    output logic                  rdat_last,
    output logic                  done,
    output logic                  err,
    output logic                  p0_cmd_en,
    output logic [2:0]            p0_cmd_instr,
    output logic [5:0]            p0_cmd_bl,
    output logic [29:0]           p0_cmd_byte_addr,
    input  logic                  p0_cmd_full,
    output logic                  p0_wr_en,
    output logic [DATA_W-1:0]     p0_wr_data,
    output logic [DATA_W/8-1:0]   p0_wr_mask,
    input  logic                  p0_wr_full,
    output logic                  p0_rd_en,
    input  logic [DATA_W-1:0]     p0_rd_data,
    input  logic                  p0_rd_empty
);
    import ddr_seq_pkg::*;

    localparam logic [6:0] L_MAX = 7'(MAX_BL);

    logic [2:0]        r_state;
    logic [29:0]       r_addr;
    logic [5:0]        r_bl;
    logic [6:0]        r_cnt;
    logic              r_err;
    logic              r_done;
    logic              r_cal_lost;
    logic              r_rdat_valid;
    logic              r_rdat_last;
    logic [DATA_W-1:0] r_rdat_data;

    logic       w_accept;
    logic       w_len_ok;
    logic       w_wr_xfer;
    logic       w_cmd_st;
    logic       w_cmd_fire;
    logic       w_pop;
    logic       w_last;
    logic       w_tmo_exp;
    logic [2:0] w_home;

    assign w_accept   = req_valid & req_ready;
    assign w_len_ok   = (req_len != 7'd0) && (req_len <= L_MAX);
    assign w_wr_xfer  = (r_state == WFILL) & wdat_valid & ~p0_wr_full;
    assign w_cmd_st   = (r_state == WCMD) | (r_state == RCMD);
    assign w_cmd_fire = w_cmd_st & ~p0_cmd_full;
    assign w_pop      = (r_state == RDRAIN) & ~p0_rd_empty;
    assign w_last     = r_cnt == {1'b0, r_bl};
    // A calibration drop seen at any point during a request diverts completion to CAL.
    assign w_home     = (r_cal_lost | ~calib_done) ? CAL : IDLE;

`ifdef DDR_SEQ_TIMEOUT_EN
    ddr_seq_timeout #(.TMO_W(TMO_W)) u_tmo (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_run     (r_state == RDRAIN),
        .i_clr     (w_pop),
        .o_expired (w_tmo_exp)
    );
`else
    assign w_tmo_exp = (TMO_W == 0);
`endif

    assign req_ready        = r_state == IDLE;
    assign wdat_ready       = (r_state == WFILL) & ~p0_wr_full;
    assign p0_wr_en         = w_wr_xfer;
    assign p0_wr_data       = wdat_data;
    assign p0_wr_mask       = '0;
    assign p0_cmd_en        = w_cmd_fire;
    assign p0_cmd_instr     = (r_state == RCMD) ? CMD_RD : CMD_WR;
    assign p0_cmd_bl        = w_cmd_st ? r_bl : 6'd0;
    assign p0_cmd_byte_addr = w_cmd_st ? r_addr : 30'd0;
    assign p0_rd_en         = w_pop;
    assign rdat_valid       = r_rdat_valid;
    assign rdat_data        = r_rdat_data;
    assign rdat_last        = r_rdat_last;
    assign done             = r_done;
    assign err              = r_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= CAL;
            r_addr       <= '0;
            r_bl         <= '0;
            r_cnt        <= '0;
            r_err        <= 1'b0;
            r_done       <= 1'b0;
            r_cal_lost   <= 1'b0;
            r_rdat_valid <= 1'b0;
            r_rdat_last  <= 1'b0;
            r_rdat_data  <= '0;
        end else begin
            r_done       <= 1'b0;
            r_rdat_valid <= 1'b0;
            r_rdat_last  <= 1'b0;
            if (r_state != CAL && !calib_done) r_cal_lost <= 1'b1;
            case (r_state)
                CAL: begin
                    r_cal_lost <= 1'b0;
                    if (calib_done) r_state <= IDLE;
                end
                IDLE:
                    if (w_accept) begin
                        r_addr <= {req_addr[29:3], 3'b000};
                        // len 64 wraps to 0 in 6 bits, so len-1 lands on 63 as required
                        r_bl   <= req_len[5:0] - 6'd1;
                        r_cnt  <= '0;
                        if (w_len_ok) r_state <= req_write ? WFILL : RCMD;
                        else begin
                            r_err   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= w_home;
                        end
                    end else if (!calib_done) r_state <= CAL;
                WFILL:
                    if (w_wr_xfer) begin
                        r_cnt <= r_cnt + 7'd1;
                        if (w_last) r_state <= WCMD;
                    end
                WCMD:
                    if (w_cmd_fire) begin
                        r_done  <= 1'b1;
                        r_state <= w_home;
                    end
                RCMD:
                    if (w_cmd_fire) r_state <= RDRAIN;
                RDRAIN:
                    if (w_pop) begin
                        r_rdat_data  <= p0_rd_data;
                        r_rdat_valid <= 1'b1;
                        r_cnt        <= r_cnt + 7'd1;
                        if (w_last) begin
                            r_rdat_last <= 1'b1;
                            r_done      <= 1'b1;
                            r_state     <= w_home;
                        end
                    end else if (w_tmo_exp) begin
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= w_home;
                    end
                default: r_state <= CAL;
            endcase
        end
    end
endmodule

// File: tb/tb_ddr_burst_sequencer.sv
// tb_ddr_burst_sequencer: randomized bench with an MCB memory/FIFO model and a request-level reference memory.
// Adds the read-drain timeout scenario when DDR_SEQ_TIMEOUT_EN is defined.
module tb_ddr_burst_sequencer;
    logic        clk = 0;
    logic        reset_n = 0;
    logic        calib_done = 0;
    logic        req_valid = 0;
    logic        req_ready;
    logic        req_write = 0;
    logic [29:0] req_addr = 0;
    logic [6:0]  req_len = 0;
    logic        wdat_valid = 0;
    logic        wdat_ready;
    logic [63:0] wdat_data = 0;
    logic        rdat_valid;
    logic [63:0] rdat_data;
    logic        rdat_last;
    logic        done;
    logic        err;
    logic        p0_cmd_en;
    logic [2:0]  p0_cmd_instr;
    logic [5:0]  p0_cmd_bl;
    logic [29:0] p0_cmd_byte_addr;
    logic        p0_cmd_full = 0;
    logic        p0_wr_en;
    logic [63:0] p0_wr_data;
    logic [7:0]  p0_wr_mask;
    logic        p0_wr_full = 0;
    logic        p0_rd_en;
    logic [63:0] p0_rd_data = 0;
    logic        p0_rd_empty = 1;

    ddr_burst_sequencer dut (
        .clk(clk), .reset_n(reset_n), .calib_done(calib_done),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat_data(wdat_data),
        .rdat_valid(rdat_valid), .rdat_data(rdat_data), .rdat_last(rdat_last),
        .done(done), .err(err),
        .p0_cmd_en(p0_cmd_en), .p0_cmd_instr(p0_cmd_instr), .p0_cmd_bl(p0_cmd_bl),
        .p0_cmd_byte_addr(p0_cmd_byte_addr), .p0_cmd_full(p0_cmd_full),
        .p0_wr_en(p0_wr_en), .p0_wr_data(p0_wr_data), .p0_wr_mask(p0_wr_mask),
        .p0_wr_full(p0_wr_full), .p0_rd_en(p0_rd_en), .p0_rd_data(p0_rd_data),
        .p0_rd_empty(p0_rd_empty)
    );

    int n_chk = 0;
    int n_err = 0;
    int n_done = 0;
    int cyc = 0;
    int mode = 0;
    bit stall = 0;
    bit short_rd = 0;
    bit rd_hold;
    logic pop_rd, take_w;
    int k;

    logic [63:0] wfq[$];
    logic [63:0] wgen[$];
    logic [63:0] mq[$];
    logic [63:0] gw[$];
    logic [38:0] cq[$];
    logic [63:0] rd_d[$];
    logic        rd_l[$];
    logic [63:0] mcb_mem[int];
    logic [63:0] ref_mem[int];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    initial forever #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // MCB side: FWFT read FIFO, write-FIFO/cmd-FIFO full flags and the write-data source
    initial forever begin
        @(posedge clk);
        pop_rd = p0_rd_en;
        take_w = wdat_valid & wdat_ready;
        #1;
        cyc++;
        if (pop_rd && mq.size() != 0) void'(mq.pop_front());
        if (take_w && wfq.size() != 0) void'(wfq.pop_front());
        p0_wr_full  = (mode == 1) ? ((cyc / 3) % 2 == 1) : (stall && $urandom_range(3) == 0);
        p0_cmd_full = (stall || mode == 1) && $urandom_range(1) == 0;
        rd_hold     = stall && $urandom_range(3) == 0;
        p0_rd_empty = (mq.size() == 0) | rd_hold;
        p0_rd_data  = (mq.size() != 0) ? mq[0] : 64'd0;
        wdat_valid  = (wfq.size() != 0) && !(stall && $urandom_range(3) == 0);
        wdat_data   = (wfq.size() != 0) ? wfq[0] : 64'd0;
    end

    always @(negedge clk) begin
        if (reset_n) begin
            if (p0_wr_en) begin
                gw.push_back(p0_wr_data);
                check("wr_full_hold", p0_wr_full, 0);
            end
            if (p0_cmd_en) begin
                check("cmd_full_hold", p0_cmd_full, 0);
                cq.push_back({p0_cmd_instr, p0_cmd_bl, p0_cmd_byte_addr});
                k = int'(p0_cmd_byte_addr >> 3);
                if (p0_cmd_instr == 3'b000)
                    for (int i = 0; i < gw.size(); i++) mcb_mem[k + i] = gw[i];
                else
                    for (int i = 0; i <= int'(p0_cmd_bl) && !(short_rd && i >= 2); i++)
                        mq.push_back(mcb_mem.exists(k + i) ? mcb_mem[k + i] : 64'd0);
            end
            if (rdat_valid) begin
                rd_d.push_back(rdat_data);
                rd_l.push_back(rdat_last);
                if (rdat_last) check("done_w_last", done, 1);
            end
            if (done) n_done++;
        end
    end

    task automatic send_req(input logic w, input logic [29:0] a, input logic [6:0] l);
        bit ok = 0;
        @(posedge clk); #1;
        req_valid = 1; req_write = w; req_addr = a; req_len = l;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = req_ready;
        end
        @(posedge clk); #1;
        req_valid = 0;
        check("accept", ok, 1);
    endtask

    task automatic wait_done(input int d0);
        for (int i = 0; i < 6000 && n_done == d0; i++) @(negedge clk);
        check("done_seen", n_done != d0, 1);
        repeat (3) @(negedge clk);
        check("done_once", n_done - d0, 1);
    endtask

    task automatic gen_random(input int l);
        wgen.delete();
        for (int i = 0; i < l; i++) wgen.push_back({$urandom, $urandom});
    endtask

    task automatic do_write(input logic [29:0] a, input int l);
        logic [63:0] exp[$];
        int d0;
        exp = wgen;
        gw.delete(); cq.delete();
        foreach (exp[i]) ref_mem[int'(a >> 3) + i] = exp[i];
        wfq = exp;
        d0 = n_done;
        send_req(1, a, 7'(l));
        wait_done(d0);
        check("wr_cnt", gw.size(), l);
        for (int i = 0; i < gw.size() && i < l; i++) check("wr_dat", gw[i], exp[i]);
        check("wr_cmd_n", cq.size(), 1);
        if (cq.size() != 0) check("wr_cmd", cq[0], {3'b000, 6'(l - 1), a & ~30'h7});
    endtask

    task automatic do_read(input logic [29:0] a, input int l);
        int d0;
        rd_d.delete(); rd_l.delete(); cq.delete();
        d0 = n_done;
        send_req(0, a, 7'(l));
        wait_done(d0);
        check("rd_cnt", rd_d.size(), l);
        for (int i = 0; i < rd_d.size() && i < l; i++) begin
            check("rd_dat", rd_d[i], ref_mem[int'(a >> 3) + i]);
            check("rd_last", rd_l[i], i == l - 1);
        end
        check("rd_cmd_n", cq.size(), 1);
        if (cq.size() != 0) check("rd_cmd", cq[0], {3'b001, 6'(l - 1), a & ~30'h7});
    endtask

    task automatic do_bad(input logic [6:0] l);
        int d0;
        cq.delete();
        d0 = n_done;
        send_req(1, 30'h40, l);
        wait_done(d0);
        check("bad_cmd", cq.size(), 0);
        check("bad_err", err, 1);
    endtask

    initial begin
        bit seen = 0;
        logic [29:0] a;
        int l;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out", {req_ready, wdat_ready, p0_wr_en, p0_cmd_en, p0_rd_en, rdat_valid,
                          rdat_last, done, err, p0_wr_mask, p0_cmd_bl, p0_cmd_byte_addr}, 0);
        reset_n = 1;
        repeat (100) begin
            @(negedge clk);
            seen |= req_ready;
        end
        check("cal_hold", seen, 0);
        @(posedge clk); #1;
        calib_done = 1;
        @(negedge clk);
        check("cal_rise_same", req_ready, 0);
        @(negedge clk);
        check("cal_rise_next", req_ready, 1);

        wgen = '{64'd9, 64'd8};
        do_write(30'h10, 2);
        do_read(30'h10, 2);

        mode = 1;
        gen_random(64);
        do_write(30'h2000, 64);
        mode = 0;
        do_read(30'h2000, 64);

        stall = 1;
        for (int t = 0; t < 8; t++) begin
            a = 30'($urandom_range(30'h3FFFFF));
            l = $urandom_range(64, 1);
            gen_random(l);
            do_write(a, l);
            do_read(a, l);
        end
        stall = 0;
        check("err_clean", err, 0);

`ifdef DDR_SEQ_TIMEOUT_EN
        begin
            int d0;
            int nl = 0;
            gen_random(4);
            do_write(30'h800, 4);
            short_rd = 1;
            rd_d.delete(); rd_l.delete();
            d0 = n_done;
            send_req(0, 30'h800, 7'd4);
            wait_done(d0);
            short_rd = 0;
            foreach (rd_l[i]) nl += int'(rd_l[i]);
            check("tmo_words", rd_d.size(), 2);
            check("tmo_no_last", nl, 0);
            check("tmo_err", err, 1);
            check("tmo_idle", req_ready, 1);
        end
`endif

        do_bad(7'd0);
        do_bad(7'd65);

        gen_random(8);
        wfq = wgen;
        send_req(1, 30'h100, 7'd8);
        repeat (2) @(negedge clk);
        #2;
        reset_n = 0;
        #1;
        check("rst_mid", {req_ready, wdat_ready, p0_wr_en, p0_cmd_en, p0_rd_en, rdat_valid,
                          rdat_last, done, err, p0_cmd_bl, p0_cmd_byte_addr}, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
